mem_port_arbiter: RTL and testbench

// Shares the single-port 256x32 word memory between the CPU instruction-fetch port
// and the CPU load/store port. Fixed data-over-fetch priority with a starvation guard,
// one grant per cycle, 1-cycle read latency, responses routed back to the granted owner.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter_starve_counter.sv | 38 +++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory port arbiter.
// Holds the default geometry, the owner encoding also used by the core and the
// memory model, the response-FSM state type and the address range helper.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_WAIT  = 3;
    localparam int unsigned MEM_WORDS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnI    = 2'd1,
        OwnD    = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        StIdle,
        StRespI,
        StRespD
    } resp_state_e;

    // True when a byte address lies above the 2**aw word window.
    function automatic logic addr_oor(input logic [31:0] addr, input int unsigned aw);
        return (addr >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the CPU ports, the arbiter and the memory array.
//   master : CPU fetch + load/store requesters and the memory array (environment side)
//   slave  : the arbiter
// Fetch:      i_req, i_addr -> i_gnt, i_rvalid, i_rdata
// Load/store: d_req, d_we, d_wstrb, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata, d_err
// Memory:     mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = mem_port_arbiter_pkg::ADDR_W,
    parameter int unsigned DATA_W = mem_port_arbiter_pkg::DATA_W
);
    logic                  i_req;
    logic [31:0]           i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_W-1:0]     i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic [31:0]           d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_err;

    logic                  mem_en;
    logic [DATA_W/8-1:0]   mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts consecutive cycles the fetch port has been refused.
//   clk, resetn : clock, asynchronous active-low reset
//   req_i       : fetch request
//   gnt_i       : fetch granted this cycle
//   at_max_o    : count has reached MaxWait, fetch must win next arbitration
module mem_port_arbiter_starve_counter #(
    parameter int unsigned MaxWait = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic req_i,
    input  logic gnt_i,
    output logic at_max_o
);
    localparam int unsigned CntW = $clog2(MaxWait + 1);

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req_i || gnt_i) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CntW'(MaxWait)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    assign at_max_o = (wait_cnt_q == CntW'(MaxWait));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between the CPU fetch and load/store ports.
// Load/store wins unless fetch has been refused MAX_WAIT cycles in a row; one grant per
// cycle, memory driven in the grant cycle, read data returned to the owner next cycle.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : mem_port_arbiter_if.slave (fetch port, load/store port, memory port)
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = mem_port_arbiter_pkg::ADDR_W,
    parameter int unsigned DATA_W   = mem_port_arbiter_pkg::DATA_W,
    parameter int unsigned MAX_WAIT = mem_port_arbiter_pkg::MAX_WAIT
) (
    input  logic                 clk,
    input  logic                 resetn,
    mem_port_arbiter_if.slave    bus
);
    import mem_port_arbiter_pkg::*;

    owner_e            win;
    logic              i_oor, d_oor, at_max;
    logic              ready_q, ready_d;
    resp_state_e       state_q, state_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    mem_port_arbiter_starve_counter #(
        .MaxWait (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .resetn   (resetn),
        .req_i    (bus.i_req),
        .gnt_i    (bus.i_gnt),
        .at_max_o (at_max)
    );

    // ready_q keeps grants off while reset is held and for the cycle it is released in.
    always_comb begin
        i_oor = addr_oor(bus.i_addr, ADDR_W);
        d_oor = addr_oor(bus.d_addr, ADDR_W);
        win   = OwnNone;
        if (ready_q) begin
            if (bus.i_req && (at_max || !bus.d_req)) begin
                win = OwnI;
            end else if (bus.d_req) begin
                win = OwnD;
            end
        end
    end

    always_comb begin
        bus.i_gnt     = (win == OwnI);
        bus.d_gnt     = (win == OwnD);
        bus.d_err     = (win == OwnD) && d_oor;
        bus.mem_en    = ((win == OwnI) && !i_oor) || ((win == OwnD) && !d_oor);
        bus.mem_we    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (win)
            OwnI: bus.mem_addr = bus.i_addr[ADDR_W+1:2];
            OwnD: begin
                bus.mem_addr = bus.d_addr[ADDR_W+1:2];
                if (bus.d_we && !d_oor) begin
                    bus.mem_we    = bus.d_wstrb;
                    bus.mem_wdata = bus.d_wdata;
                end
            end
            default: ;
        endcase
    end

    // Response owner follows this cycle's grant; stores complete at grant.
    always_comb begin
        ready_d   = 1'b1;
        state_d   = StIdle;
        zero_d    = 1'b0;
        unique case (win)
            OwnI: begin
                state_d = StRespI;
                zero_d  = i_oor;
            end
            OwnD: begin
                if (!bus.d_we) begin
                    state_d = StRespD;
                    zero_d  = d_oor;
                end
            end
            default: ;
        endcase

        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (state_q == StRespI) begin
            i_rdata_d = zero_q ? '0 : bus.mem_rdata;
        end
        if (state_q == StRespD) begin
            d_rdata_d = zero_q ? '0 : bus.mem_rdata;
        end
    end

    assign bus.i_rvalid = (state_q == StRespI);
    assign bus.d_rvalid = (state_q == StRespD);
    assign bus.i_rdata  = i_rdata_d;
    assign bus.d_rdata  = d_rdata_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q   <= 1'b0;
            state_q   <= StIdle;
            zero_q    <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            ready_q   <= ready_d;
            state_q   <= state_d;
            zero_q    <= zero_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a randomized
// run checked against a behavioural model of the arbitration and memory contents.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Memory array: read data valid the cycle after a read enable, junk otherwise.
    logic [31:0] phys_mem [256];
    logic [31:0] mem_rdata_q;
    logic        bk_we;
    logic [7:0]  bk_idx;
    logic [31:0] bk_val;
    logic [31:0] ref_mem [256];
    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        mem_rdata_q <= $urandom();
        if (bk_we) begin
            phys_mem[bk_idx] <= bk_val;
        end else if (bus.mem_en) begin
            if (bus.mem_we != 4'b0000) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_we[b]) phys_mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata_q <= phys_mem[bus.mem_addr];
            end
        end
    end
    assign bus.mem_rdata = mem_rdata_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_wstrb = 4'h0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
    endtask

    task automatic backdoor(input int idx, input logic [31:0] v);
        bk_we     = 1'b1;
        bk_idx    = 8'(idx);
        bk_val    = v;
        ref_mem[idx] = v;
        tick();
        bk_we = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) begin
            a = $urandom() | 32'h0000_0400;
        end else begin
            a = $urandom();
            a[31:AW+2] = '0;
        end
        return a;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h10;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h20;
        @(negedge clk);
        checks++; if (bus.i_gnt !== 1'b0) begin errors++; $display("FAIL reset_i_gnt got %0b want 0", bus.i_gnt); end
        checks++; if (bus.d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt got %0b want 0", bus.d_gnt); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %0b want 0", bus.mem_en); end
        checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("FAIL reset_i_rvalid got %0b want 0", bus.i_rvalid); end
        checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_d_rvalid got %0b want 0", bus.d_rvalid); end
        checks++; if (bus.d_err !== 1'b0) begin errors++; $display("FAIL reset_d_err got %0b want 0", bus.d_err); end
        checks++; if (bus.i_rdata !== 32'h0) begin errors++; $display("FAIL reset_i_rdata got %h want 0", bus.i_rdata); end
        checks++; if (bus.mem_we !== 4'h0) begin errors++; $display("FAIL reset_mem_we got %h want 0", bus.mem_we); end
        tick();
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (bus.d_gnt !== 1'b0) begin errors++; $display("FAIL release_d_gnt got %0b want 0", bus.d_gnt); end
        tick();
        @(negedge clk);
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL first_d_gnt got %0b want 1", bus.d_gnt); end
        checks++; if (bus.i_gnt !== 1'b0) begin errors++; $display("FAIL first_i_gnt got %0b want 0", bus.i_gnt); end
        tick();
        idle_reqs();
        tick();
        tick();
    endtask

    task automatic test_fetch();
        backdoor(4, 32'h0050_0513);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h10;
        @(negedge clk);
        checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt got %0b want 1", bus.i_gnt); end
        checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL fetch_mem_en got %0b want 1", bus.mem_en); end
        checks++; if (bus.mem_addr !== 8'd4) begin errors++; $display("FAIL fetch_mem_addr got %0d want 4", bus.mem_addr); end
        checks++; if (bus.mem_we !== 4'h0) begin errors++; $display("FAIL fetch_mem_we got %h want 0", bus.mem_we); end
        tick();
        bus.i_addr = 32'h14;
        @(negedge clk);
        checks++; if (bus.i_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid got %0b want 1", bus.i_rvalid); end
        checks++; if (bus.i_rdata !== 32'h0050_0513) begin errors++; $display("FAIL fetch_rdata got %h want 00500513", bus.i_rdata); end
        checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL fetch_b2b_gnt got %0b want 1", bus.i_gnt); end
        checks++; if (bus.mem_addr !== 8'd5) begin errors++; $display("FAIL fetch_b2b_addr got %0d want 5", bus.mem_addr); end
        tick();
        idle_reqs();
        @(negedge clk);
        checks++; if (bus.i_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_b2b_rvalid got %0b want 1", bus.i_rvalid); end
        checks++; if (bus.i_rdata !== ref_mem[5]) begin errors++; $display("FAIL fetch_b2b_rdata got %h want %h", bus.i_rdata, ref_mem[5]); end
        checks++; if (bus.i_gnt !== 1'b0) begin errors++; $display("FAIL fetch_idle_gnt got %0b want 0", bus.i_gnt); end
        tick();
        @(negedge clk);
        checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_drop_rvalid got %0b want 0", bus.i_rvalid); end
        checks++; if (bus.i_rdata !== ref_mem[5]) begin errors++; $display("FAIL fetch_hold_rdata got %h want %h", bus.i_rdata, ref_mem[5]); end
        tick();
    endtask

    task automatic test_contention();
        logic prev_i = 1'b0;
        logic prev_d = 1'b0;
        logic exp_i;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h30;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h44;
        for (int c = 0; c < 9; c++) begin
            exp_i = (c == 3) || (c == 7);
            @(negedge clk);
            checks++; if (bus.i_gnt !== exp_i) begin errors++; $display("FAIL contend_i_gnt c%0d got %0b want %0b", c, bus.i_gnt, exp_i); end
            checks++; if (bus.d_gnt !== !exp_i) begin errors++; $display("FAIL contend_d_gnt c%0d got %0b want %0b", c, bus.d_gnt, !exp_i); end
            checks++; if (bus.i_rvalid !== prev_i) begin errors++; $display("FAIL contend_i_rvalid c%0d got %0b want %0b", c, bus.i_rvalid, prev_i); end
            checks++; if (bus.d_rvalid !== prev_d) begin errors++; $display("FAIL contend_d_rvalid c%0d got %0b want %0b", c, bus.d_rvalid, prev_d); end
            if (prev_i) begin
                checks++; if (bus.i_rdata !== ref_mem[12]) begin errors++; $display("FAIL contend_i_rdata c%0d got %h want %h", c, bus.i_rdata, ref_mem[12]); end
            end
            if (prev_d) begin
                checks++; if (bus.d_rdata !== ref_mem[17]) begin errors++; $display("FAIL contend_d_rdata c%0d got %h want %h", c, bus.d_rdata, ref_mem[17]); end
            end
            prev_i = exp_i;
            prev_d = !exp_i;
            tick();
        end
        idle_reqs();
        tick();
        tick();
    endtask

    task automatic test_store_load();
        backdoor(8, 32'h1111_1111);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_wstrb = 4'b0011;
        bus.d_addr  = 32'h20;
        bus.d_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt got %0b want 1", bus.d_gnt); end
        checks++; if (bus.d_err !== 1'b0) begin errors++; $display("FAIL store_err got %0b want 0", bus.d_err); end
        checks++; if (bus.mem_we !== 4'b0011) begin errors++; $display("FAIL store_mem_we got %b want 0011", bus.mem_we); end
        checks++; if (bus.mem_wdata !== 32'hAABB_CCDD) begin errors++; $display("FAIL store_wdata got %h want aabbccdd", bus.mem_wdata); end
        checks++; if (bus.mem_addr !== 8'd8) begin errors++; $display("FAIL store_addr got %0d want 8", bus.mem_addr); end
        tick();
        ref_mem[8] = 32'h1111_CCDD;
        bus.d_we   = 1'b0;
        @(negedge clk);
        checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL store_rvalid got %0b want 0", bus.d_rvalid); end
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL load_gnt got %0b want 1", bus.d_gnt); end
        tick();
        idle_reqs();
        @(negedge clk);
        checks++; if (bus.d_rvalid !== 1'b1) begin errors++; $display("FAIL load_rvalid got %0b want 1", bus.d_rvalid); end
        checks++; if (bus.d_rdata !== 32'h1111_CCDD) begin errors++; $display("FAIL load_rdata got %h want 1111ccdd", bus.d_rdata); end
        tick();
    endtask

    task automatic test_out_of_range();
        backdoor(0, 32'hDEAD_BEEF);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h400;
        @(negedge clk);
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL oor_gnt got %0b want 1", bus.d_gnt); end
        checks++; if (bus.d_err !== 1'b1) begin errors++; $display("FAIL oor_err got %0b want 1", bus.d_err); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL oor_mem_en got %0b want 0", bus.mem_en); end
        tick();
        bus.d_we    = 1'b1;
        bus.d_wstrb = 4'hF;
        bus.d_addr  = 32'h800;
        bus.d_wdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if (bus.d_rvalid !== 1'b1) begin errors++; $display("FAIL oor_rvalid got %0b want 1", bus.d_rvalid); end
        checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h want 0", bus.d_rdata); end
        checks++; if (bus.d_err !== 1'b1) begin errors++; $display("FAIL oor_st_err got %0b want 1", bus.d_err); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL oor_st_mem_en got %0b want 0", bus.mem_en); end
        checks++; if (bus.mem_we !== 4'h0) begin errors++; $display("FAIL oor_st_mem_we got %h want 0", bus.mem_we); end
        tick();
        idle_reqs();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h8000_0010;
        @(negedge clk);
        checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL oor_i_gnt got %0b want 1", bus.i_gnt); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL oor_i_mem_en got %0b want 0", bus.mem_en); end
        checks++; if (bus.d_err !== 1'b0) begin errors++; $display("FAIL oor_i_d_err got %0b want 0", bus.d_err); end
        tick();
        idle_reqs();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0;
        @(negedge clk);
        checks++; if (bus.i_rvalid !== 1'b1) begin errors++; $display("FAIL oor_i_rvalid got %0b want 1", bus.i_rvalid); end
        checks++; if (bus.i_rdata !== 32'h0) begin errors++; $display("FAIL oor_i_rdata got %h want 0", bus.i_rdata); end
        tick();
        idle_reqs();
        @(negedge clk);
        checks++; if (bus.d_rdata !== ref_mem[0]) begin errors++; $display("FAIL oor_no_write got %h want %h", bus.d_rdata, ref_mem[0]); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h10;
        @(negedge clk);
        checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt got %0b want 1", bus.i_gnt); end
        resetn = 1'b0;
        #1;
        checks++; if (bus.i_gnt !== 1'b0) begin errors++; $display("FAIL midrst_gnt_drop got %0b want 0", bus.i_gnt); end
        tick();
        idle_reqs();
        @(negedge clk);
        checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got %0b want 0", bus.i_rvalid); end
        checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL midrst_d_rdata got %h want 0", bus.d_rdata); end
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_post_rvalid c%0d got %0b want 0", c, bus.i_rvalid); end
            tick();
        end
    endtask

    task automatic test_random();
        int          m_wait = 0;
        logic        m_pi = 1'b0, m_pd = 1'b0;
        logic [31:0] m_pi_data = 32'h0, m_pd_data = 32'h0;
        logic [31:0] m_last_i = 32'h0, m_last_d = 32'h0;
        logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
        logic [31:0] iaddr = 32'h0, daddr = 32'h0, dwdata = 32'h0;
        logic [3:0]  dstrb = 4'h0;
        logic        exp_i, exp_d, ioor, door, exp_en, exp_err;
        logic [7:0]  iidx, didx;
        logic [3:0]  exp_we;
        logic [31:0] exp_ir, exp_dr;
        for (int c = 0; c < 400; c++) begin
            bus.i_req   = ireq;
            bus.i_addr  = iaddr;
            bus.d_req   = dreq;
            bus.d_we    = dwe;
            bus.d_wstrb = dstrb;
            bus.d_addr  = daddr;
            bus.d_wdata = dwdata;
            @(negedge clk);
            ioor    = iaddr[31:AW+2] != '0;
            door    = daddr[31:AW+2] != '0;
            iidx    = iaddr[AW+1:2];
            didx    = daddr[AW+1:2];
            exp_i   = ireq && (m_wait == int'(MW) || !dreq);
            exp_d   = dreq && !exp_i;
            exp_en  = (exp_i && !ioor) || (exp_d && !door);
            exp_err = exp_d && door;
            exp_we  = (exp_d && dwe && !door) ? dstrb : 4'h0;
            exp_ir  = m_pi ? m_pi_data : m_last_i;
            exp_dr  = m_pd ? m_pd_data : m_last_d;
            checks++; if (bus.i_gnt !== exp_i) begin errors++; $display("FAIL rnd_i_gnt c%0d got %0b want %0b", c, bus.i_gnt, exp_i); end
            checks++; if (bus.d_gnt !== exp_d) begin errors++; $display("FAIL rnd_d_gnt c%0d got %0b want %0b", c, bus.d_gnt, exp_d); end
            checks++; if (bus.d_err !== exp_err) begin errors++; $display("FAIL rnd_d_err c%0d got %0b want %0b", c, bus.d_err, exp_err); end
            checks++; if (bus.mem_en !== exp_en) begin errors++; $display("FAIL rnd_mem_en c%0d got %0b want %0b", c, bus.mem_en, exp_en); end
            checks++; if (bus.mem_we !== exp_we) begin errors++; $display("FAIL rnd_mem_we c%0d got %h want %h", c, bus.mem_we, exp_we); end
            if (exp_en) begin
                checks++;
                if (bus.mem_addr !== (exp_i ? iidx : didx)) begin
                    errors++;
                    $display("FAIL rnd_mem_addr c%0d got %0d want %0d", c, bus.mem_addr, exp_i ? iidx : didx);
                end
            end
            checks++; if (bus.i_rvalid !== m_pi) begin errors++; $display("FAIL rnd_i_rvalid c%0d got %0b want %0b", c, bus.i_rvalid, m_pi); end
            checks++; if (bus.d_rvalid !== m_pd) begin errors++; $display("FAIL rnd_d_rvalid c%0d got %0b want %0b", c, bus.d_rvalid, m_pd); end
            checks++; if (bus.i_rdata !== exp_ir) begin errors++; $display("FAIL rnd_i_rdata c%0d got %h want %h", c, bus.i_rdata, exp_ir); end
            checks++; if (bus.d_rdata !== exp_dr) begin errors++; $display("FAIL rnd_d_rdata c%0d got %h want %h", c, bus.d_rdata, exp_dr); end

            m_last_i  = exp_ir;
            m_last_d  = exp_dr;
            m_pi      = exp_i;
            m_pi_data = ioor ? 32'h0 : ref_mem[iidx];
            m_pd      = exp_d && !dwe;
            m_pd_data = door ? 32'h0 : ref_mem[didx];
            if (exp_d && dwe && !door) begin
                for (int b = 0; b < 4; b++) begin
                    if (dstrb[b]) ref_mem[didx][8*b +: 8] = dwdata[8*b +: 8];
                end
            end
            if (ireq && !exp_i) m_wait = (m_wait < int'(MW)) ? m_wait + 1 : int'(MW);
            else m_wait = 0;

            if (!ireq || exp_i) begin
                ireq  = ($urandom_range(0, 3) != 0);
                iaddr = rand_addr();
            end
            if (!dreq || exp_d) begin
                dreq   = ($urandom_range(0, 3) != 0);
                dwe    = ($urandom_range(0, 2) == 0);
                dstrb  = 4'($urandom());
                daddr  = rand_addr();
                dwdata = $urandom();
            end
            tick();
        end
        idle_reqs();
    endtask

    initial begin
        bk_we  = 1'b0;
        bk_idx = 8'h0;
        bk_val = 32'h0;
        idle_reqs();
        #2;
        resetn = 1'b0;
        tick();
        for (int k = 0; k < 256; k++) begin
            backdoor(k, $urandom());
        end
        test_reset();
        test_fetch();
        test_contention();
        test_store_load();
        test_out_of_range();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
